fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between the instruction fetch stage and the instruction decode/control stage.
- Accepts {pc, instruction} pairs from fetch and presents them in order to decode using valid/ready handshakes on both sides.
- Decouples fetch from decode stalls.
- Supports a single-cycle flush for taken branches and jumps.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, 3, width of the occupancy count; must equal clog2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  discard all stored entries; sampled on rising edge.
- in_valid  input  1  fetch presents a valid pair.
- in_ready  output  1  queue can accept a pair this cycle.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction word of the head entry.
- count  output  CNT_W  number of stored entries, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries, 64 bits each, with wr_ptr, rd_ptr and a CNT_W-bit occupancy counter. Pointers wrap modulo DEPTH.
- Reset (rst low, asynchronous, independent of clk):
  - wr_ptr = rd_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 1.
  - out_pc = 32'd0, out_instr = 32'd0.
  - Storage contents are don't-care.
- Reset asserted mid-transfer: all state clears immediately; the in-flight pair is lost. No transfer occurs on the edge where rst is low.
- push = in_valid & in_ready. pop = out_valid & out_ready. Both are evaluated on the rising edge.
- in_ready = (count != DEPTH). This is combinational from registered count and does not depend on out_ready. A full queue never accepts a pair, even on a cycle in which it pops.
- out_valid = (count != 0). out_pc and out_instr are the head entry, read combinationally from storage at rd_ptr. When count == 0, out_pc and out_instr are 0.
- Latency: a pair pushed at edge N is visible on out_* after edge N (cycle N+1). There is no combinational bypass from in_* to out_*.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Neither: hold.
- Flush: when flush is high at an edge, wr_ptr = rd_ptr = 0, count = 0, and out_valid deasserts after the edge.
  - A simultaneous push on that edge is discarded, because the pair belongs to the wrong path.
  - A simultaneous pop is irrelevant.
  - in_ready is 1 in the cycle after a flush.
- Full: count = DEPTH, in_ready = 0. in_valid is ignored; fetch must hold its pair stable.
- Empty: count = 0, out_valid = 0. out_ready is ignored; the counter never underflows.
- Stability: while out_valid = 1 and out_ready = 0, out_pc and out_instr hold their values.
- No X may propagate to any output after reset.

Test Plan:
- Reset then idle: drive rst low for 2 cycles, then high; keep in_valid = 0 -> count = 0, out_valid = 0, in_ready = 1, out_pc = 0, out_instr = 0.
- Single push and pop: push pc = 0x00000000, instr = 0x20080005 with out_ready = 0 -> next cycle out_valid = 1, out_pc = 0, out_instr = 0x20080005, count = 1. Raise out_ready for 1 cycle -> count = 0, out_valid = 0.
- Fill to full and wrap:
  - Push pc = 0, 4, 8, 12 with out_ready = 0 -> count = 4, in_ready = 0.
  - Hold in_valid high with pc = 16 for 2 cycles -> not accepted.
  - Pop 2 -> out_pc shows 0 then 4 then 8.
  - Push pc = 16 and 20 -> pointers wrap; drain order is 8, 12, 16, 20.
- Simultaneous push and pop at count = 2: present pc = 24 and pop for one cycle -> count stays 2, out_pc advances to the next entry, pc = 24 is drained last.
- Flush with push: at count = 3, assert flush with in_valid = 1, pc = 0x40 on the same edge -> count = 0, out_valid = 0. A following push of pc = 0x80 appears as the next out_pc = 0x80.
- Asynchronous reset mid-stream: at count = 2, drop rst low between clock edges -> out_valid and count go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode. It holds {pc, instr} pairs in
// a circular buffer and supports a single-cycle flush for redirects.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a pair moves on a rising edge when valid & ready are both high on
  // that side. Ready and valid come only from the registered count, so neither
  // side sees a combinational path from the other. Once a producer raises valid,
  // it holds the pair stable until the transfer happens.
  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic [63:0]      head;

  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  assign head      = mem[rd_ptr];
  // Gate the head so an empty queue shows zeros instead of stale storage.
  assign out_pc    = out_valid ? head[63:32] : 32'd0;
  assign out_instr = out_valid ? head[31:0]  : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset. An entry is read only after it has been written.
  always_ff @(posedge clk) begin
    if (push && !flush && rst) mem[wr_ptr] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. It runs scenario tasks against a reference
// queue of {pc, instr} pairs.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] count;

  logic [63:0] exp_q[$];
  int checks;
  int errors;

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and update the reference model from the driven inputs.
  task automatic step();
    bit push;
    bit pop;
    push = in_valid && (exp_q.size() != DEPTH);
    pop  = out_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (!rst || flush) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({in_pc, in_instr});
    end
    @(negedge clk);
  endtask

  task automatic push_pair(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1; in_pc = pc; in_instr = instr;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_instr = 32'd0;
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_pc !== 32'd0 || out_instr !== 32'd0) begin
      errors++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_pc, out_instr); end
  endtask

  task automatic test_single();
    push_pair(32'h0000_0000, 32'h2008_0005);
    checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin
      errors++; $display("FAIL single_valid got v=%b c=%0d exp v=1 c=1", out_valid, count); end
    checks++; if (out_pc !== 32'd0 || out_instr !== 32'h2008_0005) begin
      errors++; $display("FAIL single_data got=%h/%h exp=00000000/20080005", out_pc, out_instr); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop got c=%0d v=%b exp c=0 v=0", count, out_valid); end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] drain_pc [4];
    drain_pc = '{32'd8, 32'd12, 32'd16, 32'd20};
    for (int i = 0; i < 4; i++) push_pair(32'(4 * i), $urandom);
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_state got c=%0d r=%b exp c=4 r=0", count, in_ready); end
    in_valid = 1'b1; in_pc = 32'd16; in_instr = 32'hdead_0010;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (count !== 3'd4 || out_pc !== exp_q[0][63:32] || out_pc !== 32'd0) begin
        errors++; $display("FAIL full_hold got c=%0d pc=%h exp c=4 pc=0", count, out_pc); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_pc !== 32'(4 * i) || out_instr !== exp_q[0][31:0]) begin
        errors++; $display("FAIL pop_order got=%h exp=%h", out_pc, 32'(4 * i)); end
      step();
    end
    out_ready = 1'b0;
    push_pair(32'd16, $urandom);
    push_pair(32'd20, $urandom);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_pc !== drain_pc[i] || out_instr !== exp_q[0][31:0]) begin
        errors++; $display("FAIL wrap_drain got=%h/%h exp=%h/%h", out_pc, out_instr, drain_pc[i], exp_q[0][31:0]); end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_empty got c=%0d v=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_simul();
    push_pair(32'h100, 32'h1111_0000);
    push_pair(32'h104, 32'h2222_0000);
    in_valid = 1'b1; in_pc = 32'd24; in_instr = 32'h3333_0000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (count !== 3'd2 || out_pc !== 32'h104) begin
      errors++; $display("FAIL simul_state got c=%0d pc=%h exp c=2 pc=104", count, out_pc); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'd24 || out_instr !== 32'h3333_0000) begin
      errors++; $display("FAIL simul_last got=%h/%h exp=00000018/33330000", out_pc, out_instr); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_pair(32'h200 + 32'(4 * i), $urandom);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h4040_4040;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got c=%0d v=%b r=%b exp 0/0/1", count, out_valid, in_ready); end
    push_pair(32'h80, 32'h8080_8080);
    checks++; if (out_pc !== 32'h80 || out_instr !== 32'h8080_8080) begin
      errors++; $display("FAIL flush_next got=%h/%h exp=00000080/80808080", out_pc, out_instr); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      checks++;
      if (count !== CNT_W'(exp_q.size()) || in_ready !== (exp_q.size() != DEPTH) ||
          out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL b2b_state got c=%0d r=%b v=%b exp c=%0d", count, in_ready, out_valid, exp_q.size());
      end
      checks++;
      if (exp_q.size() != 0) begin
        if ({out_pc, out_instr} !== exp_q[0]) begin
          errors++; $display("FAIL b2b_head got=%h%h exp=%h", out_pc, out_instr, exp_q[0]); end
      end else if ({out_pc, out_instr} !== 64'd0) begin
        errors++; $display("FAIL b2b_empty got=%h%h exp=0", out_pc, out_instr);
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_q.delete();
    flush = 1'b1; step(); flush = 1'b0;
    push_pair(32'h300, 32'h1);
    push_pair(32'h304, 32'h2);
    #2 rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'd0) begin
      errors++; $display("FAIL async_reset got c=%0d v=%b pc=%h exp 0/0/0", count, out_valid, out_pc); end
    exp_q.delete();
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h5;
    step();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_push got c=%0d v=%b exp 0/0", count, out_valid); end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fill_wrap();
    test_simul();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
